// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package seq_cmp_pkg;

    // Controller states. Code 2'd3 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result flags packed as {lt, eq, gt}; exactly one bit is set after a compare.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

endpackage

// File: rtl/seq_mag_comparator_cmp_bit_cell.sv
// One-bit magnitude cell. 'invert' swaps the gt/lt polarity so the
// sign bit of a two's-complement operand compares the right way round.
module cmp_bit_cell (
    input  logic x,
    input  logic y,
    input  logic invert,
    output logic x_gt,
    output logic x_lt,
    output logic neq
);

    logic raw_gt;
    logic raw_lt;

    assign raw_gt = x & ~y;
    assign raw_lt = ~x & y;

    // A set sign bit means negative, so under inversion a 1 loses.
    always_comb begin
        x_gt = invert ? raw_lt : raw_gt;
        x_lt = invert ? raw_gt : raw_lt;
        neq  = x ^ y;
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake.
// Scans one bit per clock and stops at the first differing bit.
module seq_mag_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sm_q, sm_d;
    logic [2:0]         res_q, res_d;

    logic bit_a, bit_b, inv;
    logic c_gt, c_lt, c_neq;

    // Selected bit pair; only the sign bit of a signed compare is inverted.
    assign bit_a = a_q[idx_q];
    assign bit_b = b_q[idx_q];
    assign inv   = sm_q && (idx_q == IDX_MSB);

    cmp_bit_cell u_cell (
        .x      (bit_a),
        .y      (bit_b),
        .invert (inv),
        .x_gt   (c_gt),
        .x_lt   (c_lt),
        .neq    (c_neq)
    );

    // Next-state, index and result logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    idx_d   = IDX_MSB;
                    res_d   = RES_NONE;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (c_neq) begin
                    res_d   = c_gt ? RES_GT : (c_lt ? RES_LT : RES_NONE);
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    res_d   = RES_EQ;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == ST_SCAN);
    assign done = (state_q == ST_DONE);
    assign lt   = res_q[2];
    assign eq   = res_q[1];
    assign gt   = res_q[0];

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator (WIDTH=8).
module tb_seq_mag_comparator;
    import seq_cmp_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       signed_mode = 1'b0;
    logic       busy, done, lt, eq, gt;

    int total = 0;
    int bad   = 0;

    seq_mag_comparator #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .eq          (eq),
        .gt          (gt)
    );

    always #5 clk = ~clk;

    // Issue one compare; lat counts posedges from the accepting edge (inclusive)
    // to the one after which done is seen; lat=0 means done never arrived.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                          output int lat, output int busy_cyc, output logic [2:0] res);
        lat = 0; busy_cyc = 0; res = '0;
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                lat = i;
                res = {lt, eq, gt};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, lt, eq, gt} !== 5'b0) begin
            bad++;
            $display("FAIL reset_state: got %b want 00000", {busy, done, lt, eq, gt});
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, lt, eq, gt} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_state: got %b want 00000", {busy, done, lt, eq, gt});
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_done: activity seen=%b want 0", seen);
        end
    endtask

    task automatic test_equal();
        int lat, bc; logic [2:0] r;
        run_op(8'hA5, 8'hA5, 1'b0, lat, bc, r);
        total++;
        if (r !== RES_EQ) begin bad++; $display("FAIL eq_result: got %b want %b", r, RES_EQ); end
        total++;
        if (lat !== 9) begin bad++; $display("FAIL eq_latency: got %0d want 9", lat); end
        total++;
        if (bc !== 8) begin bad++; $display("FAIL eq_busy_cycles: got %0d want 8", bc); end
        // one-cycle done pulse, result held in IDLE
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || {lt, eq, gt} !== RES_EQ) begin
            bad++;
            $display("FAIL eq_after_done: got done=%b busy=%b res=%b want 0 0 %b",
                     done, busy, {lt, eq, gt}, RES_EQ);
        end
    endtask

    task automatic test_msb();
        int lat, bc; logic [2:0] r;
        run_op(8'h80, 8'h7F, 1'b0, lat, bc, r);
        total++;
        if (r !== RES_GT) begin bad++; $display("FAIL msb_unsigned_result: got %b want %b", r, RES_GT); end
        total++;
        if (lat !== 2) begin bad++; $display("FAIL msb_unsigned_latency: got %0d want 2", lat); end
        run_op(8'h80, 8'h7F, 1'b1, lat, bc, r);
        total++;
        if (r !== RES_LT) begin bad++; $display("FAIL msb_signed_result: got %b want %b", r, RES_LT); end
        total++;
        if (lat !== 2) begin bad++; $display("FAIL msb_signed_latency: got %0d want 2", lat); end
        run_op(8'hFF, 8'hFE, 1'b1, lat, bc, r);
        total++;
        if (r !== RES_GT) begin bad++; $display("FAIL signed_lsb_result: got %b want %b", r, RES_GT); end
        total++;
        if (lat !== 9) begin bad++; $display("FAIL signed_lsb_latency: got %0d want 9", lat); end
        run_op(8'h7F, 8'h80, 1'b1, lat, bc, r);
        total++;
        if (r !== RES_GT) begin bad++; $display("FAIL signed_pos_neg: got %b want %b", r, RES_GT); end
    endtask

    task automatic test_lsb_ignore_start();
        int lat; bit seen;
        lat = 0;
        @(negedge clk);
        a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (i == 3) begin a = 8'hFF; start = 1'b1; end
            total++;
            if ({lt, eq, gt} !== 3'b000 && !done) begin
                bad++;
                $display("FAIL lsb_scan_flags: cycle %0d got %b want 000", i, {lt, eq, gt});
            end
            if (done) begin lat = i; break; end
        end
        start = 1'b0;
        total++;
        if ({lt, eq, gt} !== RES_LT) begin bad++; $display("FAIL lsb_result: got %b want %b", {lt, eq, gt}, RES_LT); end
        total++;
        if (lat !== 9) begin bad++; $display("FAIL lsb_latency: got %0d want 9", lat); end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || {lt, eq, gt} !== RES_LT) begin
            bad++;
            $display("FAIL lsb_no_second_op: activity=%b res=%b want 0 %b", seen, {lt, eq, gt}, RES_LT);
        end
    endtask

    task automatic test_back_to_back();
        int last, npulse;
        last = -1; npulse = 0;
        @(negedge clk);
        a = 8'h01; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 42; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                npulse++;
                total++;
                if ({lt, eq, gt} !== RES_GT) begin
                    bad++;
                    $display("FAIL b2b_result: pulse %0d got %b want %b", npulse, {lt, eq, gt}, RES_GT);
                end
                if (last >= 0) begin
                    total++;
                    if (i - last !== 10) begin
                        bad++;
                        $display("FAIL b2b_period: got %0d want 10", i - last);
                    end
                end
                last = i;
            end
        end
        start = 1'b0;
        total++;
        if (npulse !== 4) begin bad++; $display("FAIL b2b_pulse_count: got %0d want 4", npulse); end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_equal();
        test_msb();
        test_lsb_ignore_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
